// File: rtl/button_conditioner.sv
// button_conditioner: synchronizes and debounces a raw pushbutton, then emits
// a registered debounced level plus one-cycle press/release strobes.
// Optional long-hold strobe is compiled in when LONG_PRESS_EN is defined;
// without it long_pulse is tied low and LONG_CYCLES has no effect.
//
// Outputs level/press_pulse/release_pulse/long_pulse are plain registered
// signals (no valid/ready handshake); state_dbg mirrors the FSM state
// (0=IDLE, 1=PRESS_WAIT, 2=HELD, 3=RELEASE_WAIT) for observation only.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int LONG_CYCLES     = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn,
  output logic       level,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       long_pulse,
  output logic [1:0] state_dbg
);

  // Debounce counter holds 0..DEBOUNCE_CYCLES-1 and never wraps.
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  logic          sync1_q;
  logic          sync2_q;
  logic          btn_s;
  state_t        state_q;
  logic [DW-1:0] cnt_q;
  logic          level_q;
  logic          press_q;
  logic          release_q;
  logic          press_accept;
  logic          release_accept;

  // Two-flop synchronizer; only the second stage is used downstream.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
    end
  end

  assign btn_s = sync2_q;

  // The sample that completes a debounce run is the one seen while the
  // counter already holds DEBOUNCE_CYCLES-1 consecutive matching samples.
  assign press_accept   = (state_q == PRESS_WAIT)   &&  btn_s && (cnt_q == DEB_LAST);
  assign release_accept = (state_q == RELEASE_WAIT) && !btn_s && (cnt_q == DEB_LAST);

  // Debounce FSM with registered level and press/release strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (btn_s) begin
            state_q <= PRESS_WAIT;
            cnt_q   <= DW'(1);
          end
        end
        PRESS_WAIT: begin
          if (!btn_s) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (press_accept) begin
            state_q <= HELD;
            cnt_q   <= '0;
            level_q <= 1'b1;
            press_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + DW'(1);
          end
        end
        HELD: begin
          if (!btn_s) begin
            state_q <= RELEASE_WAIT;
            cnt_q   <= DW'(1);
          end
        end
        RELEASE_WAIT: begin
          if (btn_s) begin
            state_q <= HELD;
            cnt_q   <= '0;
          end else if (release_accept) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            release_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + DW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign level         = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign state_dbg     = state_q;

`ifdef LONG_PRESS_EN
  localparam int LW = $clog2(LONG_CYCLES + 1);
  localparam logic [LW-1:0] LONG_MAX = LW'(LONG_CYCLES);

  logic [LW-1:0] long_cnt_q;
  logic          long_q;
  logic          long_active;

  // Counting continues through RELEASE_WAIT so release bounces do not
  // restart the hold measurement.
  assign long_active = (state_q == HELD) || (state_q == RELEASE_WAIT);

  // Saturating hold counter; the strobe fires on the single step that reaches
  // LONG_CYCLES unless a release is being accepted on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      long_cnt_q <= '0;
      long_q     <= 1'b0;
    end else begin
      long_q <= 1'b0;
      if (press_accept) begin
        long_cnt_q <= '0;
      end else if (long_active && (long_cnt_q != LONG_MAX)) begin
        long_cnt_q <= long_cnt_q + LW'(1);
        if ((long_cnt_q == LONG_MAX - LW'(1)) && !release_accept) begin
          long_q <= 1'b1;
        end
      end
    end
  end

  assign long_pulse = long_q;
`else
  // Long-hold logic absent: port kept, tied low. The expression references
  // LONG_CYCLES only so the parameter remains part of the interface.
  assign long_pulse = (LONG_CYCLES > 0) ? 1'b0 : 1'b0;
`endif

endmodule

// File: tb/tb_button_conditioner.sv
// Testbench for button_conditioner (DEBOUNCE_CYCLES=4, LONG_CYCLES=10).
// Reference model works on run lengths of the two-edge-delayed button samples
// and on edge distances since the accepted press.
module tb_button_conditioner;

  localparam int DEB  = 4;
  localparam int LONG = 10;
`ifdef LONG_PRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic       btn   = 1'b0;
  logic       level;
  logic       press_pulse;
  logic       release_pulse;
  logic       long_pulse;
  logic [1:0] state_dbg;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  button_conditioner #(
    .DEBOUNCE_CYCLES(DEB),
    .LONG_CYCLES    (LONG)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .btn          (btn),
    .level        (level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_pulse   (long_pulse),
    .state_dbg    (state_dbg)
  );

  // Downstream toggle flop driven by press_pulse.
  logic toggle_q;
  always @(posedge clk or posedge reset) begin
    if (reset) toggle_q <= 1'b0;
    else if (press_pulse) toggle_q <= ~toggle_q;
  end

  // ---------------- reference model ----------------
  logic       samp_q[$];    // last button samples, newest at back
  logic [5:0] exp_q[$];     // {state, level, press, release, long}
  int         m_edge;
  bit         m_level;
  int         m_run;
  int         m_press_edge;

  task automatic model_reset();
    samp_q.delete();
    exp_q.delete();
    m_edge       = 0;
    m_level      = 1'b0;
    m_run        = 0;
    m_press_edge = 0;
  endtask

  task automatic model_edge(input logic b);
    logic bs;
    bit   prev;
    bit   p = 1'b0;
    bit   r = 1'b0;
    bit   l;
    logic [1:0] st;
    samp_q.push_back(b);
    bs = (samp_q.size() >= 3) ? samp_q[samp_q.size() - 3] : 1'b0;
    if (samp_q.size() > 3) void'(samp_q.pop_front());
    m_edge++;
    prev = m_level;
    if (bs != m_level) begin
      m_run++;
      if (m_run == DEB) begin
        m_level = bs;
        m_run   = 0;
        if (bs) begin
          p = 1'b1;
          m_press_edge = m_edge;
        end else begin
          r = 1'b1;
        end
      end
    end else begin
      m_run = 0;
    end
    l  = LONG_EN && prev && !r && ((m_edge - m_press_edge) == LONG);
    st = {m_level, (m_run != 0)};
    exp_q.push_back({st, m_level, p, r, l});
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_level"},   level,         1'b0);
    check({tag, "_press"},   press_pulse,   1'b0);
    check({tag, "_release"}, release_pulse, 1'b0);
    check({tag, "_long"},    long_pulse,    1'b0);
    check({tag, "_state"},   state_dbg,     2'd0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic b);
    logic [5:0] e;
    btn = b;
    @(posedge clk);
    model_edge(b);
    #1;
    e = exp_q.pop_front();
    check("m_state",   state_dbg,     e[5:4]);
    check("m_level",   level,         e[3]);
    check("m_press",   press_pulse,   e[2]);
    check("m_release", release_pulse, e[1]);
    check("m_long",    long_pulse,    e[0]);
    check("exclusive",
          ((32'(press_pulse) + 32'(release_pulse) + 32'(long_pulse)) <= 1), 1'b1);
  endtask

  // Assert reset between clock edges, confirm outputs clear at once,
  // hold for some edges, then release away from the edge.
  task automatic do_reset(input int hold);
    #3;
    reset = 1'b1;
    #1;
    check_zero("rst_async");
    model_reset();
    repeat (hold) begin
      @(posedge clk);
      #1;
      check_zero("rst_hold");
    end
    #2;
    reset = 1'b0;
  endtask

  task automatic settle_low();
    repeat (10) step(1'b0);
  endtask

  // ---------------- directed + random sequence ----------------
  int press_seen;
  int run_len;
  logic run_val;

  initial begin
    model_reset();
    do_reset(2);

    // Clean press held 30 edges: press/level at edge 6, long at edge 16.
    for (int i = 1; i <= 30; i++) begin
      step(1'b1);
      check("clean_press", press_pulse, (i == 6));
      check("clean_level", level, (i >= 6));
      check("long_hold", long_pulse, LONG_EN && (i == 16));
    end

    // Clean release: release at edge 6.
    for (int i = 1; i <= 10; i++) begin
      step(1'b0);
      check("clean_release", release_pulse, (i == 6));
      check("release_level", level, (i < 6));
    end

    // Glitch: three high samples never accepted.
    for (int i = 1; i <= 13; i++) begin
      step((i <= 3) ? 1'b1 : 1'b0);
      check("glitch_press", press_pulse, 1'b0);
      check("glitch_level", level, 1'b0);
    end
    check("glitch_idle", state_dbg, 2'd0);

    // Press, then bouncy release 0,1,0,0,0,0...; final fall is sample 3.
    repeat (10) step(1'b1);
    for (int j = 1; j <= 12; j++) begin
      step((j == 2) ? 1'b1 : 1'b0);
      check("bounce_release", release_pulse, (j == 8));
      check("bounce_level", level, (j < 8));
    end
    settle_low();

    // Release acceptance at, just before, and just after the long threshold.
    for (int k = 10; k <= 12; k++) begin
      for (int i = 1; i <= k + 9; i++) begin
        step((i < k) ? 1'b1 : 1'b0);
        check("coin_press", press_pulse, (i == 6));
        check("coin_release", release_pulse, (i == k + 5));
        check("coin_long", long_pulse, LONG_EN && (i == 16) && (k + 5 > 16));
      end
      settle_low();
    end

    // Reset while in PRESS_WAIT with count 2, button kept high.
    step(1'b1);
    step(1'b1);
    step(1'b1);
    check("pw_state", state_dbg, 2'd1);
    step(1'b1);
    do_reset(3);
    press_seen = 0;
    for (int i = 1; i <= 12; i++) begin
      step(1'b1);
      if (press_pulse === 1'b1) press_seen++;
      check("rst_press", press_pulse, (i == 6));
    end
    check("rst_press_count", 8'(press_seen), 8'd1);
    check("toggle_once", toggle_q, 1'b1);
    settle_low();

    // Reset asserted while HELD: level drops immediately, no pulses after.
    repeat (8) step(1'b1);
    check("held_level", level, 1'b1);
    do_reset(2);
    settle_low();

    // Randomized runs of constant button level, occasional resets.
    for (int n = 0; n < 60; n++) begin
      run_val = 1'($urandom_range(0, 1));
      run_len = int'($urandom_range(1, 14));
      repeat (run_len) step(run_val);
      if ($urandom_range(0, 24) == 0) do_reset(int'($urandom_range(1, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 DEBOUNCE_CYCLES, default 20, consecutive stable synchronized samples needed to accept a level change (legal 2..2^20).
REQ-002 LONG_CYCLES, default 100, clk edges after press acceptance before long_pulse (legal 2..2^24).
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 btn  input  1  raw asynchronous pushbutton, active-high, bouncy.
REQ-006 level  output  1  debounced registered button state.
REQ-007 press_pulse  output  1  one-cycle strobe on accepted press; drives the t input of a downstream toggle flop.
REQ-008 release_pulse  output  1  one-cycle strobe on accepted release.
REQ-009 long_pulse  output  1  one-cycle strobe on long hold.

Function
REQ-010 btn SHALL pass a 2-flop synchronizer; only its second stage (btn_s) feeds further logic.
REQ-011 The FSM SHALL have states IDLE (level=0), PRESS_WAIT, HELD (level=1), RELEASE_WAIT.
REQ-012 IDLE: btn_s=1 -> PRESS_WAIT with debounce count 1; else stay.
REQ-013 PRESS_WAIT: btn_s=0 -> IDLE, count cleared, no output change; btn_s=1 on the DEBOUNCE_CYCLES-th consecutive sample -> HELD, level=1, press_pulse=1 for exactly one cycle.
REQ-014 HELD: btn_s=0 -> RELEASE_WAIT with count 1; else stay.
REQ-015 RELEASE_WAIT: btn_s=1 -> HELD, no pulse; btn_s=0 on the DEBOUNCE_CYCLES-th consecutive sample -> IDLE, level=0, release_pulse=1 for one cycle.
REQ-016 Latency: with edge 1 the first edge sampling btn high (low), level/press_pulse (release_pulse) SHALL change at edge DEBOUNCE_CYCLES+2.
REQ-017 Debounce counter width SHALL be ceil(log2(DEBOUNCE_CYCLES+1)); it SHALL never wrap.
REQ-018 Long counter SHALL clear on press acceptance, increment each edge in HELD or RELEASE_WAIT, saturate at LONG_CYCLES; bounces into RELEASE_WAIT SHALL NOT restart it.
REQ-019 long_pulse SHALL assert one cycle when the long counter reaches LONG_CYCLES, at most once per accepted press.
REQ-020 If release acceptance and long threshold coincide, release_pulse SHALL assert and long_pulse SHALL be suppressed.
REQ-021 press_pulse, release_pulse, long_pulse SHALL never assert in the same cycle and SHALL all be registered outputs.

Reset
REQ-022 reset=1 SHALL immediately force synchronizer flops, counters, and all outputs to 0 and FSM to IDLE, independent of clk.
REQ-023 Reset mid-operation SHALL discard any partial debounce or long count; no pulse SHALL be emitted during or on release of reset.
REQ-024 btn held high through reset deassertion SHALL be treated as a fresh press (press_pulse at edge DEBOUNCE_CYCLES+2 after first post-reset edge).

Configuration
REQ-025 Macro LONG_PRESS_EN: defined -> long counter and REQ-018..REQ-020 logic compiled in.
REQ-026 LONG_PRESS_EN undefined -> long counter absent, long_pulse port retained and tied to 0, LONG_CYCLES ignored; all other behaviour identical.

Verification (DEBOUNCE_CYCLES=4, LONG_CYCLES=10)
REQ-027 Clean press: btn 0->1 held 20 cycles -> level and press_pulse rise at edge 6; press_pulse high exactly 1 cycle.
REQ-028 Glitch: btn high 3 cycles then low -> no pulse, level stays 0, FSM back to IDLE.
REQ-029 Bouncy release: from HELD, btn 0,1,0,0,0,0 -> no pulse during bounce; release_pulse once, level=0 at 6th edge after the final falling sample.
REQ-030 Long hold, macro defined: btn held 30 cycles -> press_pulse at edge 6, long_pulse exactly once at edge 16; macro undefined -> long_pulse never asserts.
REQ-031 Reset in PRESS_WAIT (count=2) with btn staying high -> outputs 0 during reset; press_pulse at edge 6 after reset release; feeding press_pulse to a toggle flop yields exactly one toggle.
